// File: rtl/prime_bitmap_arbiter.sv
// Two-requester round-robin arbiter for the prime bitmap RAM read port, with
// a read-latency pipeline that forwards in-flight writes to the returning read.
`timescale 1ns/1ps
module prime_bitmap_arbiter #(
  parameter int AW     = 20,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic          rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic          rdata1,
  input  logic          wea,
  input  logic [AW-1:0] w_addr,
  input  logic          w_data,
  output logic [AW-1:0] ram_addrb,
  input  logic          ram_doutb,
  output logic          busy
);

  typedef struct packed {
    logic          own;
    logic [AW-1:0] addr;
    logic          byp;
    logic          bdat;
  } entry_t;

  logic [RD_LAT-1:0] vld_pipe;
  entry_t            pipe [RD_LAT];
  logic              ptr;
  logic [AW-1:0]     addr_q;
  logic              accept;
  entry_t            new_e;
  entry_t            tail;
  logic              tail_vld;
  logic              tail_dat;

  // Any write landing on an in-flight address makes the RAM's answer stale.
  function automatic entry_t snoop(input entry_t e, input logic we,
                                   input logic [AW-1:0] wa, input logic wd);
    entry_t r;
    r = e;
    if (we && (wa == e.addr)) begin
      r.byp  = 1'b1;
      r.bdat = wd;
    end
    return r;
  endfunction

  assign gnt0   = rstn & req0 & (~req1 | ~ptr);
  assign gnt1   = rstn & req1 & (~req0 |  ptr);
  assign accept = gnt0 | gnt1;

  assign ram_addrb = gnt0 ? addr0 : (gnt1 ? addr1 : addr_q);

  assign new_e = '{own: gnt1, addr: ram_addrb, byp: 1'b0, bdat: 1'b0};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      ptr      <= 1'b0;
      addr_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      addr_q <= ram_addrb;
      if (accept) ptr <= gnt0;
      vld_pipe[0] <= accept;
      pipe[0]     <= snoop(new_e, wea, w_addr, w_data);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pipe[i]     <= snoop(pipe[i-1], wea, w_addr, w_data);
      end
    end
  end

  assign tail     = pipe[RD_LAT-1];
  assign tail_vld = vld_pipe[RD_LAT-1];
  assign tail_dat = tail.byp ? tail.bdat : ram_doutb;

  assign rvalid0 = tail_vld & ~tail.own;
  assign rvalid1 = tail_vld &  tail.own;
  assign rdata0  = rvalid0 & tail_dat;
  assign rdata1  = rvalid1 & tail_dat;
  assign busy    = |vld_pipe;

endmodule

// File: tb/tb_prime_bitmap_arbiter.sv
// Directed bench: stimulus queues expected read returns, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_prime_bitmap_arbiter;
  localparam int AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, req0, req1, wea, w_data, ram_doutb;
  logic [AW-1:0] addr0, addr1, w_addr, ram_addrb;
  logic          gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy;

  prime_bitmap_arbiter #(.AW(AW), .RD_LAT(2)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .wea(wea), .w_addr(w_addr), .w_data(w_data),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb), .busy(busy)
  );

  // Read-first RAM, two-edge latency; only the low 64 addresses exist.
  logic mem [64];
  logic d1;
  always @(posedge clk) begin
    d1        <= (ram_addrb[AW-1:6] == '0) ? mem[ram_addrb[5:0]] : 1'b0;
    ram_doutb <= d1;
    if (wea && (w_addr[AW-1:6] == '0)) mem[w_addr[5:0]] <= w_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit own;
    bit dat;
    int cyc;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int eg = 0, eb = 0, ea = 0;
  bit armed = 0, done = 0, final_done = 0;

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      tests++;
      if (gnt0 !== (eg == 1) || gnt1 !== (eg == 2)) begin
        fails++;
        $display("FAIL grant cyc=%0d got gnt0=%b gnt1=%b want code %0d", cyc, gnt0, gnt1, eg);
      end
      if (eb >= 0) begin
        tests++;
        if (busy !== eb[0]) begin
          fails++;
          $display("FAIL busy cyc=%0d got %b want %0d", cyc, busy, eb);
        end
      end
      if (ea >= 0) begin
        tests++;
        if (ram_addrb !== ea[AW-1:0]) begin
          fails++;
          $display("FAIL ram_addrb cyc=%0d got %0d want %0d", cyc, ram_addrb, ea);
        end
      end
      tests++;
      if ((rvalid0 !== 1'b1 && rdata0 !== 1'b0) || (rvalid1 !== 1'b1 && rdata1 !== 1'b0)) begin
        fails++;
        $display("FAIL rdata_idle cyc=%0d got rdata0=%b rdata1=%b want 0", cyc, rdata0, rdata1);
      end
      if (rvalid0 || rvalid1) begin
        tests++;
        if (rvalid0 && rvalid1) begin
          fails++;
          $display("FAIL rvalid_both cyc=%0d got both set want one", cyc);
        end else if (q.size() == 0) begin
          fails++;
          $display("FAIL rvalid_unexpected cyc=%0d got rvalid0=%b rvalid1=%b want none", cyc, rvalid0, rvalid1);
        end else begin
          e = q.pop_front();
          if (e.own !== rvalid1 || e.dat !== (rvalid1 ? rdata1 : rdata0) || e.cyc != cyc) begin
            fails++;
            $display("FAIL read_return cyc=%0d got own=%b data=%b want own=%b data=%b cyc=%0d",
                     cyc, rvalid1, (rvalid1 ? rdata1 : rdata0), e.own, e.dat, e.cyc);
          end
        end
      end
      if (done && !final_done) begin
        tests++;
        final_done = 1;
        if (q.size() != 0) begin
          fails++;
          $display("FAIL missing_returns got %0d outstanding want 0", q.size());
        end
      end
    end
  end

  // rs, req0/addr0, req1/addr1, write, then expected grant code, busy, ram_addrb, read data (-1 = none)
  task automatic st(input bit rs, input bit r0, input int a0, input bit r1, input int a1,
                    input bit we, input int wa, input bit wd,
                    input int g, input int b, input int a, input int d);
    @(posedge clk);
    #1;
    rstn   = rs;
    req0   = r0;
    addr0  = a0[AW-1:0];
    req1   = r1;
    addr1  = a1[AW-1:0];
    wea    = we;
    w_addr = wa[AW-1:0];
    w_data = wd;
    eg     = g;
    eb     = b;
    ea     = a;
    if (d >= 0) q.push_back('{own: (g == 2), dat: d[0], cyc: cyc + 2});
    armed  = 1;
  endtask

  task automatic idle(input int b, input int a);
    st(1, 0, 0, 0, 0, 0, 0, 0, 0, b, a, -1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish before 100us");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 1'b0;
    mem[3] = 1'b1;
    mem[7] = 1'b1;
    mem[9] = 1'b1;
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    wea = 1'b0; w_addr = '0; w_data = 1'b0;

    // requests held during reset must not be granted
    st(0, 1, 7, 1, 3, 0, 0, 0, 0, 0, 0, -1);
    st(0, 1, 7, 1, 3, 0, 0, 0, 0, 0, 0, -1);
    st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);

    // single read of bit 7
    st(1, 1, 7, 0, 0, 0, 0, 0, 1, 0, 7, 1);
    idle(1, 7); idle(1, 7); idle(0, 7);

    // contention from a fresh reset: 0,1,0,1,0,1
    st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    for (int i = 0; i < 6; i++)
      st(1, 1, 3, 1, 4, 0, 0, 0, (i % 2) + 1, (i == 0) ? 0 : 1, (i % 2) ? 4 : 3, (i % 2) ? 0 : 1);
    idle(1, 4); idle(1, 4); idle(0, 4);

    // write to the read address one edge later is forwarded
    st(1, 1, 12, 0, 0, 0, 0, 0, 1, 0, 12, 1);
    st(1, 0, 0, 0, 0, 1, 12, 1, 0, 1, 12, -1);
    idle(1, 12); idle(0, 12);
    st(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 12, -1);
    // write to a neighbouring address is not
    st(1, 1, 12, 0, 0, 0, 0, 0, 1, 0, 12, 0);
    st(1, 0, 0, 0, 0, 1, 13, 1, 0, 1, 12, -1);
    idle(1, 12); idle(0, 12);

    // address differing only in the MSB must not match
    st(1, 0, 0, 1, 12, 1, (1 << 19) | 12, 1, 2, 0, 12, 0);
    idle(1, 12); idle(1, 12); idle(0, 12);

    // two writes in the window: the later one wins
    st(1, 1, 20, 0, 0, 1, 20, 1, 1, 0, 20, 0);
    st(1, 0, 0, 0, 0, 1, 20, 0, 0, 1, 20, -1);
    idle(1, 20); idle(0, 20);

    // write on the acceptance edge itself
    st(1, 0, 0, 1, 5, 1, 5, 1, 2, 0, 5, 1);
    idle(1, 5); idle(1, 5); idle(0, 5);

    // reset with two reads in flight: neither returns
    st(1, 1, 7, 1, 3, 0, 0, 0, 1, 0, 7, -1);
    st(1, 1, 7, 1, 3, 0, 0, 0, 2, 1, 3, -1);
    repeat (3) st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    st(1, 0, 0, 1, 9, 0, 0, 0, 2, 0, 9, 1);
    idle(1, 9); idle(1, 9); idle(0, 9);

    // long idle: nothing moves, address holds
    repeat (100) idle(0, 9);

    done = 1;
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
